game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
- Central timing controller for game logic and VGA update pacing.
- Owns one shared WIDTH-bit reload down-counter and sequences it through start, pause, resume and stop.
- Reprograms the tick period from the current game level, so play speeds up as the level rises.
- Emits a one-cycle frame tick, a divided movement strobe, and a running tick count for the block-drop, draw and score logic.

Parameters:
- WIDTH, 26, counter and delay width.
- LEVEL_W, 4, level input width.
- BASE_DELAY, 833332, level-0 reload value; period is BASE_DELAY+1 cycles (60 Hz at 50 MHz).
- STEP, 20000, reload reduction per level.
- MIN_DELAY, 200000, lower clamp on the effective reload value.
- DIV, 4, ticks per move strobe; DIV>=1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  begin ticking; honoured only in IDLE.
- pause  in  1  freeze counter; honoured only in RUN.
- resume  in  1  continue from frozen count; honoured only in PAUSED.
- stop  in  1  return to IDLE from any state.
- level_valid  in  1  new level offered.
- level  in  LEVEL_W  requested game level.
- level_ready  out  1  scheduler can accept a level.
- tick  out  1  one-cycle period pulse.
- move  out  1  one-cycle pulse on every DIV-th tick.
- tick_count  out  16  ticks since last start; wraps.
- cur_delay  out  WIDTH  reload value in force.
- busy  out  1  state != IDLE.
- state  out  2  IDLE=00, RUN=01, PAUSED=10.

Behaviour:
- Reset values: state=IDLE, count=BASE_DELAY, cur_delay=BASE_DELAY, pending level cleared, level_ready=1, tick=0, move=0, tick_count=0, div counter=0, busy=0.
- Reset mid-operation discards everything, including any pending level.
- Command priority in one cycle: stop > pause > resume > start. Commands not valid in the current state are ignored.
- IDLE + start:
  - go to RUN; count <= cur_delay; tick_count <= 0; div <= 0.
- RUN:
  - count != 0: count decrements by 1 each cycle.
  - count == 0: count <= cur_delay, or the pending delay if one exists.
  - Registered tick=1 in the following cycle.
  - First tick appears cur_delay+1 cycles after the start edge; period is cur_delay+1 cycles.
- On each tick:
  - tick_count increments (0xFFFF -> 0x0000).
  - div increments, wrapping at DIV-1.
  - move=1 in the same cycle as the tick on which div wraps, i.e. ticks DIV, 2*DIV, ...
  - With DIV=1, move equals tick.
- RUN + pause:
  - go to PAUSED; count frozen; no tick/move.
  - If pause coincides with count==0, pause wins: no reload and no tick that cycle, count stays 0.
- PAUSED + resume:
  - go to RUN; decrementing continues from the frozen value.
  - Next tick is delayed by exactly the number of cycles spent paused.
- stop in any state:
  - go to IDLE; count <= cur_delay; div <= 0; tick/move low next cycle.
  - tick_count holds its value until the next start.
- Level handshake:
  - Transfer occurs on level_valid && level_ready.
  - level_ready = !pending.
- Effective delay (product computed at WIDTH+LEVEL_W bits, no truncation):
  - eff = BASE_DELAY - level*STEP.
  - If level*STEP > BASE_DELAY, or eff < MIN_DELAY, then eff = MIN_DELAY.
- Applying the accepted level:
  - In IDLE or PAUSED: cur_delay <= eff on the next edge; pending never set. In PAUSED the frozen count is unchanged.
  - In RUN: eff held pending; applied to cur_delay and count at the next reload; pending clears there and level_ready returns to 1.
  - Transfer in RUN coincident with count==0: the reload uses the old value and the new level stays pending one more period.
- Outputs are all registered except busy and level_ready, which decode from registered state.

Test Plan:
(Overrides for all cases: BASE_DELAY=9, STEP=2, MIN_DELAY=3, DIV=3, WIDTH=8, LEVEL_W=4.)
- Reset, start pulse at edge E0 -> tick high after E10, E20, E30, ...; move high only with the 3rd and 6th ticks; tick_count reads 1, 2, 3 after each tick; busy=1.
- In RUN, offer level=2 mid-period -> level_ready=0 until the next reload; cur_delay becomes 5; subsequent tick spacing is 6 cycles; level_ready=1 after the reload.
- In IDLE, level=5 (10 > 9) -> cur_delay=3; level=3 (9-6=3) -> cur_delay=3; level=1 -> cur_delay=7; start -> period 8.
- RUN with count=4, pause 7 cycles, then resume -> no tick while PAUSED; next tick 7 cycles later than the unpaused case; pause coincident with count==0 yields no tick until after resume.
- Assert pause and stop together in RUN -> IDLE, tick=0; start again -> first tick cur_delay+1 cycles later, tick_count restarts at 1.
- resetn low mid-RUN with a level pending -> all reset values next cycle, cur_delay=9, level_ready=1, state=00.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// Frame/move tick scheduler: one reload down-counter sequenced through IDLE/RUN/PAUSED,
// with a level-driven reload value that is handed over at the next period boundary while running.
module game_tick_scheduler #(
    parameter int unsigned WIDTH      = 26,
    parameter int unsigned LEVEL_W    = 4,
    parameter int unsigned BASE_DELAY = 833332,
    parameter int unsigned STEP       = 20000,
    parameter int unsigned MIN_DELAY  = 200000,
    parameter int unsigned DIV        = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               pause,
    input  logic               resume,
    input  logic               stop,
    input  logic               level_valid,
    input  logic [LEVEL_W-1:0] level,
    output logic               level_ready,
    output logic               tick,
    output logic               move,
    output logic [15:0]        tick_count,
    output logic [WIDTH-1:0]   cur_delay,
    output logic               busy,
    output logic [1:0]         state
);
    localparam int unsigned PROD_W = WIDTH + LEVEL_W;
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   cur_delay_q, cur_delay_d;
    logic [WIDTH-1:0]   pend_delay_q, pend_delay_d;
    logic               pending_q, pending_d;
    logic               tick_q, tick_d;
    logic               move_q, move_d;
    logic [15:0]        tick_count_q, tick_count_d;
    logic [DIV_W-1:0]   div_q, div_d;

    logic [PROD_W-1:0]  level_prod;
    logic [PROD_W-1:0]  level_diff;
    logic [WIDTH-1:0]   eff_delay;
    logic               xfer;
    logic               advance;
    logic               reload;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            count_q      <= WIDTH'(BASE_DELAY);
            cur_delay_q  <= WIDTH'(BASE_DELAY);
            pend_delay_q <= '0;
            pending_q    <= 1'b0;
            tick_q       <= 1'b0;
            move_q       <= 1'b0;
            tick_count_q <= '0;
            div_q        <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cur_delay_q  <= cur_delay_d;
            pend_delay_q <= pend_delay_d;
            pending_q    <= pending_d;
            tick_q       <= tick_d;
            move_q       <= move_d;
            tick_count_q <= tick_count_d;
            div_q        <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start)  state_d = RUN;
                RUN:     if (pause)  state_d = PAUSED;
                PAUSED:  if (resume) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Product is kept at full width so a large level can never wrap below BASE_DELAY.
    always_comb begin
        level_prod = PROD_W'(level) * PROD_W'(STEP);
        level_diff = PROD_W'(BASE_DELAY) - level_prod;
        if ((level_prod > PROD_W'(BASE_DELAY)) || (level_diff < PROD_W'(MIN_DELAY))) begin
            eff_delay = WIDTH'(MIN_DELAY);
        end else begin
            eff_delay = WIDTH'(level_diff);
        end
    end

    // The resume edge already counts as a running cycle, so the tick slips by exactly the PAUSED time.
    assign xfer    = level_valid && !pending_q;
    assign advance = !stop && (((state_q == RUN) && !pause) || ((state_q == PAUSED) && resume));
    assign reload  = advance && (count_q == '0);

    always_comb begin
        count_d      = count_q;
        cur_delay_d  = cur_delay_q;
        pend_delay_d = pend_delay_q;
        pending_d    = pending_q;
        tick_d       = 1'b0;
        move_d       = 1'b0;
        tick_count_d = tick_count_q;
        div_d        = div_q;

        if (stop) begin
            count_d = cur_delay_q;
            div_d   = '0;
        end else if ((state_q == IDLE) && start) begin
            count_d      = cur_delay_q;
            tick_count_d = '0;
            div_d        = '0;
        end else if (reload) begin
            if (pending_q) begin
                count_d     = pend_delay_q;
                cur_delay_d = pend_delay_q;
                pending_d   = 1'b0;
            end else begin
                count_d = cur_delay_q;
            end
            tick_d       = 1'b1;
            tick_count_d = tick_count_q + 16'd1;
            if (div_q == DIV_W'(DIV - 1)) begin
                div_d  = '0;
                move_d = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end else if (advance) begin
            count_d = count_q - 1'b1;
        end

        // A level taken while running waits for the next period boundary.
        if (xfer) begin
            if (state_q == RUN) begin
                pending_d    = 1'b1;
                pend_delay_d = eff_delay;
            end else begin
                cur_delay_d = eff_delay;
            end
        end
    end

    always_comb begin
        tick        = tick_q;
        move        = move_q;
        tick_count  = tick_count_q;
        cur_delay   = cur_delay_q;
        state       = state_q;
        busy        = (state_q != IDLE);
        level_ready = !pending_q;
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized commands.
module tb_game_tick_scheduler;
    localparam int WIDTH   = 8;
    localparam int LEVEL_W = 4;
    localparam int BASE    = 9;
    localparam int STEP    = 2;
    localparam int MIN_D   = 3;
    localparam int DIV     = 3;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               start = 1'b0, pause = 1'b0, resume = 1'b0, stop = 1'b0;
    logic               level_valid = 1'b0;
    logic [LEVEL_W-1:0] level = '0;

    logic               level_ready, tick, move, busy;
    logic [15:0]        tick_count;
    logic [WIDTH-1:0]   cur_delay;
    logic [1:0]         state;

    logic               d1_ready, d1_tick, d1_move, d1_busy;
    logic [15:0]        d1_tc;
    logic [WIDTH-1:0]   d1_cur;
    logic [1:0]         d1_state;

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;

    game_tick_scheduler #(
        .WIDTH(WIDTH), .LEVEL_W(LEVEL_W), .BASE_DELAY(BASE),
        .STEP(STEP), .MIN_DELAY(MIN_D), .DIV(DIV)
    ) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .pause(pause), .resume(resume),
        .stop(stop), .level_valid(level_valid), .level(level), .level_ready(level_ready),
        .tick(tick), .move(move), .tick_count(tick_count), .cur_delay(cur_delay),
        .busy(busy), .state(state)
    );

    game_tick_scheduler #(
        .WIDTH(WIDTH), .LEVEL_W(LEVEL_W), .BASE_DELAY(BASE),
        .STEP(STEP), .MIN_DELAY(MIN_D), .DIV(1)
    ) u_dut_div1 (
        .clk(clk), .resetn(resetn), .start(start), .pause(pause), .resume(resume),
        .stop(stop), .level_valid(level_valid), .level(level), .level_ready(d1_ready),
        .tick(d1_tick), .move(d1_move), .tick_count(d1_tc), .cur_delay(d1_cur),
        .busy(d1_busy), .state(d1_state)
    );

    function automatic int eff_of(input int lv);
        int p;
        p = lv * STEP;
        if (p > BASE || (BASE - p) < MIN_D) return MIN_D;
        return BASE - p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Model: the next tick is an absolute edge number; every edge that does not run pushes it one later.
    int m_state = 0, m_tc = 0, m_ticks = 0, m_cur = BASE, m_pv = 0, m_next = 0;
    bit m_pend = 0, m_tick = 0, m_move = 0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_state = 0; m_tc = 0; m_ticks = 0; m_cur = BASE; m_pv = 0; m_next = 0;
            m_pend = 0; m_tick = 0; m_move = 0;
        end else begin : step
            int eff_v, prev;
            bit old_pend, fire, xfer;
            prev     = m_state;
            old_pend = m_pend;
            xfer     = level_valid && !m_pend;
            eff_v    = eff_of(int'(level));
            fire     = 0;
            m_tick   = 0;
            m_move   = 0;
            if (stop) begin
                m_state = 0;
            end else if (prev == 0) begin
                if (start) begin
                    m_state = 1; m_next = ecount + m_cur + 1; m_tc = 0; m_ticks = 0;
                end
            end else if (prev == 1) begin
                if (pause) begin m_state = 2; m_next++; end
                else fire = (ecount == m_next);
            end else begin
                if (resume) begin m_state = 1; fire = (ecount == m_next); end
                else m_next++;
            end
            if (fire) begin
                if (old_pend) begin m_cur = m_pv; m_pend = 0; end
                m_next  = ecount + m_cur + 1;
                m_ticks++;
                m_tc    = (m_tc + 1) % 65536;
                m_tick  = 1;
                m_move  = (m_ticks % DIV) == 0;
            end
            if (xfer) begin
                if (prev == 1) begin m_pend = 1; m_pv = eff_v; end
                else m_cur = eff_v;
            end
        end
        ecount++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tick", tick, m_tick);
            check("move", move, m_move);
            check("tick_count", tick_count, m_tc);
            check("cur_delay", cur_delay, m_cur);
            check("state", state, m_state);
            check("busy", busy, m_state != 0);
            check("level_ready", level_ready, !m_pend);
            check("d1_tick", d1_tick, m_tick);
            check("d1_move", d1_move, m_tick);
            check("d1_tick_count", d1_tc, m_tc);
            check("d1_cur_delay", d1_cur, m_cur);
            check("d1_state", d1_state, m_state);
            check("d1_busy", d1_busy, m_state != 0);
            check("d1_level_ready", d1_ready, !m_pend);
        end
    end

    task automatic wait_tick(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                at = ecount;
                break;
            end
        end
        if (at < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_tick: no tick within 200 cycles (edge %0d)", ecount);
        end
    endtask

    task automatic pulse_level(input int lv);
        level_valid = 1'b1;
        level = LEVEL_W'(lv);
        @(negedge clk);
        level_valid = 1'b0;
    endtask

    initial begin
        int e0, t1, t2, t3, t4, t5, t6, t;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_cur_delay", cur_delay, 9);
        check("rst_ready", level_ready, 1);
        check("rst_tick_count", tick_count, 0);
        check("rst_busy", busy, 0);
        resetn = 1'b1;
        @(negedge clk);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = ecount;
        check("run_busy", busy, 1);
        wait_tick(t1);
        check("lat_first", t1 - e0, 10);
        check("tc_1", tick_count, 1);
        check("move_1", move, 0);
        wait_tick(t2);
        check("period_2", t2 - t1, 10);
        check("tc_2", tick_count, 2);
        check("move_2", move, 0);
        wait_tick(t3);
        check("period_3", t3 - t2, 10);
        check("tc_3", tick_count, 3);
        check("move_3", move, 1);

        pulse_level(2);
        check("pend_ready", level_ready, 0);
        check("pend_cur_old", cur_delay, 9);
        wait_tick(t4);
        check("period_4", t4 - t3, 10);
        check("cur_after_reload", cur_delay, 5);
        check("ready_after_reload", level_ready, 1);
        wait_tick(t5);
        check("period_5", t5 - t4, 6);
        check("tc_5", tick_count, 5);

        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("paused_state", state, 2);
        repeat (6) @(negedge clk);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("resumed_state", state, 1);
        wait_tick(t6);
        check("period_paused", t6 - t5, 13);

        repeat (5) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("pause_at_zero_tick", tick, 0);
        check("pause_at_zero_state", state, 2);
        @(negedge clk);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("resume_zero_tick", tick, 1);
        check("resume_zero_tc", tick_count, 7);

        pause = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        stop = 1'b0;
        check("stop_state", state, 0);
        check("stop_tick", tick, 0);
        check("stop_tc_hold", tick_count, 7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = ecount;
        wait_tick(t);
        check("restart_lat", t - e0, 6);
        check("restart_tc", tick_count, 1);

        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        pulse_level(5);
        check("idle_lvl5", cur_delay, 3);
        pulse_level(3);
        check("idle_lvl3", cur_delay, 3);
        pulse_level(1);
        check("idle_lvl1", cur_delay, 7);
        check("idle_ready", level_ready, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = ecount;
        wait_tick(t1);
        check("lvl1_lat", t1 - e0, 8);
        wait_tick(t2);
        check("lvl1_period", t2 - t1, 8);

        pulse_level(4);
        check("rst_pend_ready", level_ready, 0);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_state", state, 0);
        check("midrst_cur", cur_delay, 9);
        check("midrst_ready", level_ready, 1);
        check("midrst_tick", tick, 0);
        check("midrst_tc", tick_count, 0);
        check("midrst_busy", busy, 0);
        resetn = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start       = ($urandom_range(0, 99) < 8);
            pause       = ($urandom_range(0, 99) < 4);
            resume      = ($urandom_range(0, 99) < 10);
            stop        = ($urandom_range(0, 99) < 2);
            level_valid = ($urandom_range(0, 99) < 10);
            level       = LEVEL_W'($urandom_range(0, 15));
            resetn      = ($urandom_range(0, 999) != 0);
        end
        @(negedge clk);
        start = 1'b0; pause = 1'b0; resume = 1'b0; stop = 1'b0;
        level_valid = 1'b0; resetn = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
